load_handshake_ctrl: RTL and testbench

Destination-domain controller for a toggle-based load handshake across a clock-domain crossing. It synchronizes the source's request toggle through a `load_sync` instance and waits a programmable settle time. It then captures the quasi-static source data bus, presents it downstream on a valid/ready interface, and returns an acknowledge toggle to the source. It sits at the receive side of every multi-bit configuration or load path that crosses into `clk`.

---
 rtl/load_hs_pkg.sv | 13 +
 rtl/load_sync.sv | 32 +++
 rtl/load_handshake_ctrl.sv | 128 ++++++++++++
 tb/tb_load_handshake_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/load_hs_pkg.sv
// Shared types and constants for the destination-side load handshake controller.
package load_hs_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        PRESENT = 2'd2,
        ACK     = 2'd3
    } load_hs_state_t;

    localparam int LOAD_HS_CNT_W = 4;

endpackage

// File: rtl/load_sync.sv
// Multi-flop synchronizer bringing a single asynchronous level into the clk domain.
module load_sync #(
    parameter int NUM_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [NUM_STAGES-1:0] sync_reg;
    logic [NUM_STAGES-1:0] chain_in;

    // Stage gi samples chain_in[gi]: the raw input for stage 0, the previous stage otherwise.
    assign chain_in = {sync_reg[NUM_STAGES-2:0], d};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync_reg[gi] <= 1'b0;
                end else begin
                    sync_reg[gi] <= chain_in[gi];
                end
            end
        end
    endgenerate

    assign q = sync_reg[NUM_STAGES-1];

endmodule

// File: rtl/load_handshake_ctrl.sv
// Receive side of a toggle load handshake: synchronize request, settle, capture data,
// present it on valid/ready, then return an acknowledge toggle.
module load_handshake_ctrl
    import load_hs_pkg::*;
#(
    parameter int DATA_W        = 8,
    parameter int NUM_STAGES    = 2,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_tgl_async,
    input  logic [DATA_W-1:0] data_async,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              ack_tgl,
    output logic              busy,
    output logic              overrun,
    input  logic              clr_overrun
);

    localparam bit SKIP_SETTLE = (SETTLE_CYCLES == 0);
    localparam logic [LOAD_HS_CNT_W-1:0] SETTLE_LOAD =
        SKIP_SETTLE ? '0 : LOAD_HS_CNT_W'(SETTLE_CYCLES - 1);

    logic                     req_s;
    logic                     req_s_d_reg;
    logic                     req_edge;
    load_hs_state_t           state_reg, state_next;
    logic [LOAD_HS_CNT_W-1:0] cnt_reg, cnt_next;
    logic [DATA_W-1:0]        out_data_reg;
    logic                     out_valid_reg;
    logic                     ack_tgl_reg;
    logic                     overrun_reg, overrun_next;
    logic                     capture;
    logic                     ack_flip;

    load_sync #(
        .NUM_STAGES(NUM_STAGES)
    ) u_req_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (req_tgl_async),
        .q    (req_s)
    );

    assign req_edge = req_s ^ req_s_d_reg;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        capture    = 1'b0;
        ack_flip   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_edge) begin
                    if (SKIP_SETTLE) begin
                        capture    = 1'b1;
                        state_next = PRESENT;
                    end else begin
                        cnt_next   = SETTLE_LOAD;
                        state_next = SETTLE;
                    end
                end
            end
            SETTLE: begin
                if (cnt_reg == '0) begin
                    capture    = 1'b1;
                    state_next = PRESENT;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            PRESENT: begin
                if (out_valid_reg && out_ready) begin
                    state_next = ACK;
                end
            end
            ACK: begin
                ack_flip   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // A request edge outside IDLE is dropped; set dominates a simultaneous clear.
    always_comb begin
        overrun_next = overrun_reg;
        if (req_edge && (state_reg != IDLE)) begin
            overrun_next = 1'b1;
        end else if (clr_overrun) begin
            overrun_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            req_s_d_reg   <= 1'b0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            ack_tgl_reg   <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            req_s_d_reg   <= req_s;
            out_valid_reg <= (state_next == PRESENT);
            overrun_reg   <= overrun_next;
            if (capture) begin
                out_data_reg <= data_async;
            end
            if (ack_flip) begin
                ack_tgl_reg <= ~ack_tgl_reg;
            end
        end
    end

    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;
    assign ack_tgl   = ack_tgl_reg;
    assign overrun   = overrun_reg;
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_load_handshake_ctrl.sv
// Directed bench: instance A (N=2, S=2) covers timing, overrun, stall and reset;
// instance B (N=2, S=0) covers the zero-settle path.
module tb_load_handshake_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data_async;
    logic       clr_overrun;
    logic       req_a, ready_a, req_b, ready_b;
    logic [7:0] data_a, data_b;
    logic       valid_a, ack_a, busy_a, ovr_a;
    logic       valid_b, ack_b, busy_b, ovr_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    load_handshake_ctrl #(.DATA_W(8), .NUM_STAGES(2), .SETTLE_CYCLES(2)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .req_tgl_async(req_a), .data_async(data_async),
        .out_data(data_a), .out_valid(valid_a), .out_ready(ready_a), .ack_tgl(ack_a),
        .busy(busy_a), .overrun(ovr_a), .clr_overrun(clr_overrun)
    );

    load_handshake_ctrl #(.DATA_W(8), .NUM_STAGES(2), .SETTLE_CYCLES(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .req_tgl_async(req_b), .data_async(data_async),
        .out_data(data_b), .out_valid(valid_b), .out_ready(ready_b), .ack_tgl(ack_b),
        .busy(busy_b), .overrun(ovr_b), .clr_overrun(clr_overrun)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; data_async = 8'h00; clr_overrun = 1'b0;
        req_a = 1'b0; ready_a = 1'b0; req_b = 1'b0; ready_b = 1'b0;
        #12;
        chk("rst_valid_a", valid_a, 0); chk("rst_data_a", data_a, 0);
        chk("rst_ack_a", ack_a, 0);     chk("rst_busy_a", busy_a, 0);
        chk("rst_ovr_a", ovr_a, 0);     chk("rst_valid_b", valid_b, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) step();

        // T1: plain transfer, ready held high
        data_async = 8'hA5; ready_a = 1'b1; req_a = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            step();
            chk($sformatf("t1_valid_e%0d", e), valid_a, (e == 5) ? 1 : 0);
            if (e == 2) chk("t1_busy_e2", busy_a, 0);
            if (e == 3) chk("t1_busy_e3", busy_a, 1);
            if (e == 5) begin
                chk("t1_data", data_a, 8'hA5);
                data_async = 8'h3C;
            end
            if (e == 6) begin
                chk("t1_data_frozen", data_a, 8'hA5);
                chk("t1_ack_e6", ack_a, 0);
                chk("t1_busy_e6", busy_a, 1);
            end
            if (e == 7) begin
                chk("t1_ack_e7", ack_a, 1);
                chk("t1_busy_e7", busy_a, 0);
            end
        end
        $display("T1 transfer 0xA5 done, ack_a=%0d", ack_a);

        // T2: second toggle lands in SETTLE -> overrun, only one valid
        data_async = 8'h11; req_a = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            step();
            if (e == 2) req_a = 1'b1;
            if (e == 4) chk("t2_ovr_e4", ovr_a, 0);
            if (e == 5) begin
                chk("t2_valid", valid_a, 1);
                chk("t2_data", data_a, 8'h11);
                chk("t2_ovr_e5", ovr_a, 1);
            end
            if (e == 7) chk("t2_ack", ack_a, 0);
        end
        for (int k = 0; k < 12; k++) begin
            step();
            chk("t2_no_2nd_valid", valid_a, 0);
        end
        chk("t2_ovr_sticky", ovr_a, 1);
        $display("T2 transfer 0x11 with dropped request done, overrun=%0d", ovr_a);

        clr_overrun = 1'b1;
        step();
        clr_overrun = 1'b0;
        chk("clr_ovr", ovr_a, 0);

        // T3: downstream stall for 10 cycles, plus illegal edge with simultaneous clear
        data_async = 8'h5A; ready_a = 1'b0; req_a = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            step();
            if (e == 4) chk("t3_valid_e4", valid_a, 0);
        end
        chk("t3_valid_e5", valid_a, 1);
        req_a = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk("t3_hold_valid", valid_a, 1);
            chk("t3_hold_data", data_a, 8'h5A);
            chk("t3_hold_ack", ack_a, 0);
            if (k == 2) begin
                chk("t3_ovr_before", ovr_a, 0);
                clr_overrun = 1'b1;
            end
            if (k == 3) begin
                chk("t3_set_wins", ovr_a, 1);
                clr_overrun = 1'b0;
            end
            if (k == 5) data_async = 8'h99;
        end
        ready_a = 1'b1;
        step();
        chk("t3_valid_fall", valid_a, 0);
        chk("t3_busy_ack", busy_a, 1);
        chk("t3_ack_not_yet", ack_a, 0);
        step();
        chk("t3_ack", ack_a, 1);
        chk("t3_busy_done", busy_a, 0);
        $display("T3 stalled transfer 0x5A done, ack_a=%0d", ack_a);

        // T4: reset asserted during PRESENT, request high at release
        data_async = 8'h77; ready_a = 1'b0; req_a = 1'b0;
        repeat (5) step();
        chk("t4_valid", valid_a, 1);
        chk("t4_data", data_a, 8'h77);
        req_a = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t4_rst_valid", valid_a, 0); chk("t4_rst_data", data_a, 0);
        chk("t4_rst_ack", ack_a, 0);     chk("t4_rst_busy", busy_a, 0);
        chk("t4_rst_ovr", ovr_a, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        data_async = 8'hE1; ready_a = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            step();
            if (e == 4) chk("t4_post_valid_e4", valid_a, 0);
        end
        chk("t4_post_valid_e5", valid_a, 1);
        chk("t4_post_data", data_a, 8'hE1);
        repeat (4) step();
        $display("T4 reset abort and restart 0xE1 done");

        // T5: zero settle cycles on instance B
        data_async = 8'hC3; ready_b = 1'b1; req_b = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            step();
            if (e == 2) chk("t5_valid_e2", valid_b, 0);
            if (e == 3) begin
                chk("t5_valid_e3", valid_b, 1);
                chk("t5_data", data_b, 8'hC3);
                data_async = 8'h3C;
            end
            if (e == 4) begin
                chk("t5_valid_e4", valid_b, 0);
                chk("t5_data_frozen", data_b, 8'hC3);
            end
            if (e == 5) chk("t5_ack", ack_b, 1);
        end
        $display("T5 zero-settle transfer 0xC3 done, ack_b=%0d", ack_b);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
